// File: rtl/ext_subsys_ctrl_pkg.sv
// Shared types, register map and helpers for the external accelerator power/interrupt manager.
package ext_subsys_ctrl_pkg;

    localparam int unsigned MAX_NACC = 16;
    localparam int unsigned ADDR_W   = 8;

    localparam logic [ADDR_W-1:0] REG_CTRL    = 8'h00;
    localparam logic [ADDR_W-1:0] REG_STATUS  = 8'h04;
    localparam logic [ADDR_W-1:0] REG_PENDING = 8'h08;
    localparam logic [ADDR_W-1:0] REG_MASK    = 8'h0C;
    localparam logic [ADDR_W-1:0] REG_ERRCLR  = 8'h10;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_PWR_UP,
        ST_HOLD,
        ST_RUN,
        ST_CLK_OFF,
        ST_PWR_DN,
        ST_FAIL
    } acc_state_e;

    typedef struct packed {
        logic switch_n;
        logic iso_n;
        logic rst_n;
        logic clk_en;
    } pwr_ctrl_t;

    // Control pin levels driven while a channel sits in a given state.
    function automatic pwr_ctrl_t state_ctrl(acc_state_e s);
        pwr_ctrl_t c;
        c = '{switch_n: 1'b1, iso_n: 1'b0, rst_n: 1'b0, clk_en: 1'b0};
        case (s)
            ST_PWR_UP, ST_CLK_OFF: c.switch_n = 1'b0;
            ST_HOLD: c = '{switch_n: 1'b0, iso_n: 1'b1, rst_n: 1'b0, clk_en: 1'b1};
            ST_RUN:  c = '{switch_n: 1'b0, iso_n: 1'b1, rst_n: 1'b1, clk_en: 1'b1};
            default: ;
        endcase
        return c;
    endfunction

    function automatic int unsigned cnt_width(int unsigned ack_timeout, int unsigned rst_hold);
        int unsigned m;
        m = (ack_timeout > rst_hold) ? ack_timeout : rst_hold;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/acc_pwr_fsm.sv
// One accelerator channel: power switch / isolation / reset / clock sequencing with ack timeout.
module acc_pwr_fsm
    import ext_subsys_ctrl_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned RST_HOLD    = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_i,
    input  logic err_clr_i,
    input  logic switch_ack_ni,
    output logic switch_no,
    output logic iso_no,
    output logic rst_no,
    output logic clk_en_o,
    output logic running_o,
    output logic err_o
);

    localparam int unsigned CNT_W = cnt_width(ACK_TIMEOUT, RST_HOLD);

    acc_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_d;
    pwr_ctrl_t        pwr_d;

    // Next state; transitional states always run to completion.
    always_comb begin
        state_d = state_q;
        err_d   = err_o;
        case (state_q)
            ST_OFF:     if (req_i && !err_o) state_d = ST_PWR_UP;
            ST_PWR_UP: begin
                if (!switch_ack_ni)                   state_d = ST_HOLD;
                else if (cnt_q == CNT_W'(ACK_TIMEOUT)) state_d = ST_FAIL;
            end
            ST_HOLD:    if (cnt_q == CNT_W'(RST_HOLD - 1)) state_d = ST_RUN;
            ST_RUN:     if (!req_i) state_d = ST_CLK_OFF;
            ST_CLK_OFF: state_d = ST_PWR_DN;
            ST_PWR_DN: begin
                if (switch_ack_ni)                    state_d = ST_OFF;
                else if (cnt_q == CNT_W'(ACK_TIMEOUT)) state_d = ST_FAIL;
            end
            ST_FAIL:    if (err_clr_i) state_d = ST_OFF;
            default:    state_d = ST_OFF;
        endcase

        if (state_d == ST_FAIL) err_d = 1'b1;
        else if (err_clr_i)     err_d = 1'b0;

        cnt_d = '0;
        if (state_d == state_q &&
            (state_q == ST_PWR_UP || state_q == ST_HOLD || state_q == ST_PWR_DN)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        pwr_d = state_ctrl(state_d);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_OFF;
            cnt_q     <= '0;
            err_o     <= 1'b0;
            running_o <= 1'b0;
            switch_no <= 1'b1;
            iso_no    <= 1'b0;
            rst_no    <= 1'b0;
            clk_en_o  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_o     <= err_d;
            running_o <= (state_d == ST_RUN);
            switch_no <= pwr_d.switch_n;
            iso_no    <= pwr_d.iso_n;
            rst_no    <= pwr_d.rst_n;
            clk_en_o  <= pwr_d.clk_en;
        end
    end

endmodule

// File: rtl/ext_subsys_ctrl.sv
// Register-mapped power, reset and interrupt manager for NACC external accelerators.
module ext_subsys_ctrl
    import ext_subsys_ctrl_pkg::*;
#(
    parameter int unsigned NACC        = 2,
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned RST_HOLD    = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  reg_req_t        reg_req_i,
    output reg_rsp_t        reg_rsp_o,
    input  logic [NACC-1:0] switch_ack_ni,
    input  logic [NACC-1:0] acc_int_i,
    output logic [NACC-1:0] switch_no,
    output logic [NACC-1:0] iso_no,
    output logic [NACC-1:0] acc_rst_no,
    output logic [NACC-1:0] clk_en_o,
    output logic [NACC-1:0] intr_o
);

    logic [NACC-1:0]   ctrl_q, ctrl_d, mask_q, pending_q, int_q;
    logic [NACC-1:0]   running, err, err_clr, w1c, int_set, wdata_ch;
    logic [ADDR_W-1:0] offset;
    logic [31:0]       rdata;
    logic              hit, wr_en;
    logic              unused_req;

    assign offset     = reg_req_i.addr[ADDR_W-1:0];
    assign wdata_ch   = reg_req_i.wdata[NACC-1:0];
    assign unused_req = ^{reg_req_i.addr[31:ADDR_W], reg_req_i.wdata[31:NACC], reg_req_i.wstrb};

    // Read mux and address decode.
    always_comb begin
        hit   = 1'b1;
        rdata = '0;
        case (offset)
            REG_CTRL:    rdata = 32'(ctrl_q);
            REG_STATUS:  rdata = {16'(err), 16'(running)};
            REG_PENDING: rdata = 32'(pending_q);
            REG_MASK:    rdata = 32'(mask_q);
            REG_ERRCLR:  rdata = '0;
            default:     hit = 1'b0;
        endcase
    end

    assign reg_rsp_o = '{rdata: rdata, error: reg_req_i.valid && !hit, ready: 1'b1};
    assign wr_en     = reg_req_i.valid && reg_req_i.write && hit;

    // FSMs see the CTRL value being written this cycle so PWR_UP follows the write directly.
    assign ctrl_d  = (wr_en && offset == REG_CTRL)    ? wdata_ch : ctrl_q;
    assign err_clr = (wr_en && offset == REG_ERRCLR)  ? wdata_ch : '0;
    assign w1c     = (wr_en && offset == REG_PENDING) ? wdata_ch : '0;
    assign int_set = running & acc_int_i & ~int_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_q    <= '0;
            mask_q    <= '0;
            pending_q <= '0;
            int_q     <= '0;
            intr_o    <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            if (wr_en && offset == REG_MASK) mask_q <= wdata_ch;
            pending_q <= (pending_q & ~w1c) | int_set;
            int_q     <= running & acc_int_i;
            intr_o    <= pending_q & mask_q;
        end
    end

    for (genvar i = 0; i < NACC; i++) begin : g_ch
        acc_pwr_fsm #(
            .ACK_TIMEOUT(ACK_TIMEOUT),
            .RST_HOLD   (RST_HOLD)
        ) u_fsm (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .req_i        (ctrl_d[i]),
            .err_clr_i    (err_clr[i]),
            .switch_ack_ni(switch_ack_ni[i]),
            .switch_no    (switch_no[i]),
            .iso_no       (iso_no[i]),
            .rst_no       (acc_rst_no[i]),
            .clk_en_o     (clk_en_o[i]),
            .running_o    (running[i]),
            .err_o        (err[i])
        );
    end

endmodule

// File: tb/tb_ext_subsys_ctrl.sv
// Scoreboard bench for ext_subsys_ctrl: power sequencing, timeout, interrupts, register errors.
module tb_ext_subsys_ctrl;
    import ext_subsys_ctrl_pkg::*;

    localparam int unsigned NACC = 2;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    reg_req_t        reg_req;
    reg_rsp_t        reg_rsp;
    logic [NACC-1:0] switch_ack_ni, acc_int_i;
    logic [NACC-1:0] switch_no, iso_no, acc_rst_no, clk_en_o, intr_o;

    logic [NACC-1:0] e_sw, e_iso, e_rst, e_ce, e_ir;
    logic [31:0]     exp_q[$];
    string           tag_q[$];
    int              n_total = 0;
    int              n_bad   = 0;

    ext_subsys_ctrl #(.NACC(NACC), .ACK_TIMEOUT(255), .RST_HOLD(4)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .reg_req_i    (reg_req),
        .reg_rsp_o    (reg_rsp),
        .switch_ack_ni(switch_ack_ni),
        .acc_int_i    (acc_int_i),
        .switch_no    (switch_no),
        .iso_no       (iso_no),
        .acc_rst_no   (acc_rst_no),
        .clk_en_o     (clk_en_o),
        .intr_o       (intr_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        chk(t, obs, e);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_pins(input string tag);
        sb_push(tag, 32'({e_ir, e_ce, e_rst, e_iso, e_sw}));
        sb_pop(32'({intr_o, clk_en_o, acc_rst_no, iso_no, switch_no}));
    endtask

    task automatic reg_write(input logic [7:0] addr, input logic [31:0] data);
        reg_req = '{addr: 32'(addr), write: 1'b1, wdata: data, wstrb: 4'hF, valid: 1'b1};
        tick();
        reg_req = '0;
    endtask

    task automatic reg_read(input logic [7:0] addr, input logic [31:0] exp_d, input logic exp_e,
                            input string tag);
        sb_push(tag, exp_d);
        sb_push({tag, "_err"}, 32'(exp_e));
        reg_req = '{addr: 32'(addr), write: 1'b0, wdata: '0, wstrb: 4'h0, valid: 1'b1};
        #1;
        sb_pop(reg_rsp.rdata);
        sb_pop(32'(reg_rsp.error));
        reg_req = '0;
        tick();
    endtask

    task automatic set_off_pins();
        e_sw = 2'b11; e_iso = 2'b00; e_rst = 2'b00; e_ce = 2'b00; e_ir = 2'b00;
    endtask

    initial begin
        rst_ni        = 1'b0;
        reg_req       = '0;
        switch_ack_ni = 2'b11;
        acc_int_i     = 2'b00;
        set_off_pins();
        repeat (3) @(posedge clk_i);
        #1;
        check_pins("reset_pins");
        rst_ni = 1'b1;
        tick();
        reg_read(REG_CTRL,    32'h0, 1'b0, "rst_ctrl");
        reg_read(REG_MASK,    32'h0, 1'b0, "rst_mask");
        reg_read(REG_PENDING, 32'h0, 1'b0, "rst_pend");
        reg_read(REG_STATUS,  32'h0, 1'b0, "rst_status");

        // Channel 0 power-up, ack three cycles after the switch closes.
        reg_write(REG_CTRL, 32'h1);
        e_sw = 2'b10;
        check_pins("pwrup_entry");
        repeat (3) tick();
        check_pins("pwrup_wait");
        switch_ack_ni = 2'b10;
        tick();
        e_iso = 2'b01; e_ce = 2'b01;
        for (int i = 0; i < 4; i++) begin
            check_pins($sformatf("hold%0d", i));
            tick();
        end
        e_rst = 2'b01;
        check_pins("run0");
        reg_read(REG_STATUS, 32'h1, 1'b0, "status_run0");

        // Channel 1 power-up with immediate ack.
        reg_write(REG_CTRL, 32'h3);
        e_sw = 2'b00;
        check_pins("ch1_pwrup");
        switch_ack_ni = 2'b00;
        tick();
        e_iso = 2'b11; e_ce = 2'b11;
        check_pins("ch1_hold");
        repeat (4) tick();
        e_rst = 2'b11;
        check_pins("ch1_run");
        reg_read(REG_STATUS, 32'h3, 1'b0, "status_run01");

        // Interrupt on channel 1.
        reg_write(REG_MASK, 32'h3);
        reg_read(REG_MASK, 32'h3, 1'b0, "mask_rd");
        acc_int_i = 2'b10;
        tick();
        check_pins("intr_lat1");
        acc_int_i = 2'b00;
        tick();
        e_ir = 2'b10;
        check_pins("intr_lat2");
        reg_read(REG_PENDING, 32'h2, 1'b0, "pend_set");
        acc_int_i = 2'b10;
        reg_write(REG_PENDING, 32'h2);
        acc_int_i = 2'b00;
        reg_read(REG_PENDING, 32'h2, 1'b0, "pend_set_wins");
        reg_write(REG_PENDING, 32'h2);
        reg_read(REG_PENDING, 32'h0, 1'b0, "pend_w1c");
        e_ir = 2'b00;
        check_pins("intr_cleared");

        // Channel 0 power-down.
        reg_write(REG_CTRL, 32'h2);
        e_sw = 2'b00; e_iso = 2'b10; e_rst = 2'b10; e_ce = 2'b10;
        check_pins("clk_off");
        tick();
        e_sw = 2'b01;
        check_pins("pwr_dn");
        switch_ack_ni = 2'b01;
        tick();
        reg_read(REG_STATUS, 32'h2, 1'b0, "status_dn");

        // Edge on a channel that is off must not pend.
        acc_int_i = 2'b01;
        tick();
        acc_int_i = 2'b00;
        tick();
        reg_read(REG_PENDING, 32'h0, 1'b0, "pend_off_ch");

        // Channel 0 ack timeout.
        reg_write(REG_CTRL, 32'h3);
        e_sw = 2'b00;
        check_pins("to_start");
        repeat (255) tick();
        check_pins("to_last");
        tick();
        e_sw = 2'b01;
        check_pins("to_fail");
        reg_read(REG_STATUS, 32'h0001_0002, 1'b0, "status_fail");
        reg_write(REG_CTRL, 32'h3);
        repeat (2) tick();
        check_pins("fail_ignores_ctrl");
        reg_write(REG_CTRL, 32'h2);
        reg_write(REG_ERRCLR, 32'h1);
        reg_read(REG_STATUS, 32'h2, 1'b0, "status_errclr");
        reg_write(REG_CTRL, 32'h3);
        e_sw = 2'b00;
        check_pins("re_pwrup");

        // Back to RUN, then reset in the middle of power-down.
        switch_ack_ni = 2'b00;
        tick();
        repeat (4) tick();
        e_iso = 2'b11; e_rst = 2'b11; e_ce = 2'b11;
        check_pins("run_again");
        acc_int_i = 2'b10;
        tick();
        acc_int_i = 2'b00;
        tick();
        e_ir = 2'b10;
        check_pins("intr_before_rst");
        reg_write(REG_CTRL, 32'h2);
        tick();
        e_sw = 2'b01; e_iso = 2'b10; e_rst = 2'b10; e_ce = 2'b10;
        check_pins("pwr_dn_before_rst");
        rst_ni = 1'b0;
        #1;
        set_off_pins();
        check_pins("rst_mid_pwr_dn");
        switch_ack_ni = 2'b11;
        rst_ni = 1'b1;
        tick();
        reg_read(REG_CTRL,    32'h0, 1'b0, "rst2_ctrl");
        reg_read(REG_PENDING, 32'h0, 1'b0, "rst2_pend");
        reg_read(REG_STATUS,  32'h0, 1'b0, "rst2_status");
        reg_read(8'h14,       32'h0, 1'b1, "unmapped");
        check_pins("final_pins");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
